// File: rtl/ro_race_pkg.sv
// ro_race_pkg
//   Shared types and constants for the oscillator race counter.
//   race_state_e : controller state (IDLE, RUN, DONE)
//   CNT_W        : default counter width
//   CNT_MAX      : saturation value for CNT_W-bit counters
//   TIMEOUT_DEF  : default RUN-state cycle limit for a dead oscillator
package ro_race_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } race_state_e;

    localparam int              CNT_W       = 8;
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam int              TIMEOUT_DEF = 4096;

endpackage

// File: rtl/ro_race_counter_if.sv
// ro_race_counter_if
//   Groups the measurement-controller handshake, the two oscillator inputs
//   and the race results.
//   start         : 1-cycle pulse, begin a race (from controller)
//   osc_a, osc_b  : free-running oscillators, asynchronous to clk
//   count1/count2 : edge counts of osc_a/osc_b (frozen in DONE)
//   busy, done    : race in progress / race finished
//   tie, timeout  : both saturated together / ended by the cycle limit
//   master = controller + oscillator side, slave = counter block.
interface ro_race_counter_if
    import ro_race_pkg::*;
#(
    parameter int WIDTH = CNT_W
);
    logic             start;
    logic             osc_a;
    logic             osc_b;
    logic [WIDTH-1:0] count1;
    logic [WIDTH-1:0] count2;
    logic             busy;
    logic             done;
    logic             tie;
    logic             timeout;

    modport master (
        output start, osc_a, osc_b,
        input  count1, count2, busy, done, tie, timeout
    );

    modport slave (
        input  start, osc_a, osc_b,
        output count1, count2, busy, done, tie, timeout
    );
endinterface

// File: rtl/sync_edge_det.sv
// sync_edge_det
//   Brings an asynchronous oscillator into the clk domain through a
//   SYNC_STG-flop synchronizer and flags each synchronized rising edge.
//   clk   : system clock
//   rst_n : async active-low reset, clears all flops
//   d     : asynchronous input
//   rise  : one-cycle pulse per synchronized rising edge of d
module sync_edge_det #(
    parameter int SYNC_STG = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);
    logic [SYNC_STG-1:0] sync_q;
    logic                s_d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            s_d_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STG-2:0], d};
            s_d_q  <= sync_q[SYNC_STG-1];
        end
    end

    assign rise = sync_q[SYNC_STG-1] & ~s_d_q;
endmodule

// File: rtl/ro_race_counter.sv
// ro_race_counter
//   Counts rising edges of two oscillators in parallel and freezes both
//   counts as soon as either reaches all-ones, or when TIMEOUT RUN cycles
//   pass without saturation. One race per rising transition of start.
//   clk   : system clock
//   rst_n : async active-low reset
//   bus   : slave side of ro_race_counter_if (start, osc_a/b in;
//           count1/2, busy, done, tie, timeout out)
module ro_race_counter
    import ro_race_pkg::*;
#(
    parameter int WIDTH    = CNT_W,
    parameter int SYNC_STG = 2,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ro_race_counter_if.slave     bus
);
    localparam int               TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WIDTH-1:0] MAXV  = {WIDTH{1'b1}};
    localparam logic [TW-1:0]    TLAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]    TMAX  = {TW{1'b1}};

    race_state_e      state_q, state_d;
    logic [WIDTH-1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;
    logic [WIDTH-1:0] nxt1, nxt2;
    logic [TW-1:0]    timer_q, timer_d;
    logic             tie_q, tie_d, tmo_q, tmo_d;
    logic             busy_q, done_q;
    logic             start_d_q, start_rise;
    logic             inc_a, inc_b;
    logic             sat_a, sat_b;

    sync_edge_det #(.SYNC_STG(SYNC_STG)) u_sync_a (
        .clk (clk), .rst_n (rst_n), .d (bus.osc_a), .rise (inc_a)
    );
    sync_edge_det #(.SYNC_STG(SYNC_STG)) u_sync_b (
        .clk (clk), .rst_n (rst_n), .d (bus.osc_b), .rise (inc_b)
    );

    // Saturating increment: a counter at all-ones never wraps.
    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v,
                                                 input logic             inc);
        return (inc && (v != MAXV)) ? v + WIDTH'(1) : v;
    endfunction

    // A held-high start launches only one race.
    assign start_rise = bus.start & ~start_d_q;

    assign nxt1  = sat_inc(cnt1_q, inc_a);
    assign nxt2  = sat_inc(cnt2_q, inc_b);
    assign sat_a = (nxt1 == MAXV);
    assign sat_b = (nxt2 == MAXV);

    always_comb begin
        state_d = state_q;
        cnt1_d  = cnt1_q;
        cnt2_d  = cnt2_q;
        timer_d = timer_q;
        tie_d   = tie_q;
        tmo_d   = tmo_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_rise) begin
                    state_d = RUN;
                    cnt1_d  = '0;
                    cnt2_d  = '0;
                    timer_d = '0;
                    tie_d   = 1'b0;
                    tmo_d   = 1'b0;
                end
            end
            RUN: begin
                // Both counters take this cycle's increment, even on the
                // edge where one of them saturates.
                cnt1_d  = nxt1;
                cnt2_d  = nxt2;
                timer_d = (timer_q == TMAX) ? timer_q : timer_q + TW'(1);
                // Saturation outranks a coincident timeout.
                if (sat_a || sat_b) begin
                    state_d = DONE;
                    tie_d   = sat_a & sat_b;
                end else if (timer_q == TLAST) begin
                    state_d = DONE;
                    tmo_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt1_q    <= '0;
            cnt2_q    <= '0;
            timer_q   <= '0;
            tie_q     <= 1'b0;
            tmo_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            start_d_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt1_q    <= cnt1_d;
            cnt2_q    <= cnt2_d;
            timer_q   <= timer_d;
            tie_q     <= tie_d;
            tmo_q     <= tmo_d;
            busy_q    <= (state_d == RUN);
            done_q    <= (state_d == DONE);
            start_d_q <= bus.start;
        end
    end

    assign bus.count1  = cnt1_q;
    assign bus.count2  = cnt2_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.tie     = tie_q;
    assign bus.timeout = tmo_q;
endmodule
